// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/mem/writeback over a
// req/ready memory handshake, latches datapath controls and flags illegal opcodes.
module multicycle_control_unit #(
    parameter int OPCODE_W  = 6,
    parameter int FUNCT_W   = 6,
    parameter int ALUCTRL_W = 3,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [ALUCTRL_W-1:0] alucntrl,
    output logic                 ALUsrc,
    output logic                 immsel,
    output logic                 memtoreg,
    output logic                 regWrite,
    output logic                 illegal,
    output logic [CNT_W-1:0]     instr_count
);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

    localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] FN_SLL = FUNCT_W'(6'b000000);
    localparam logic [FUNCT_W-1:0] FN_SRL = FUNCT_W'(6'b000010);
    localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        K_ALU,
        K_LOAD,
        K_STORE
    } kind_t;

    state_t               state_q, state_d;
    kind_t                kind_q, kind_d;
    logic [ALUCTRL_W-1:0] alucntrl_q, alucntrl_d;
    logic                 alusrc_q, alusrc_d;
    logic                 immsel_q, immsel_d;
    logic                 memtoreg_q, memtoreg_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic       dec_legal;
    logic [2:0] dec_alu;
    logic       dec_src;
    logic       dec_imm;
    logic       dec_m2r;
    kind_t      dec_kind;

    // Instruction decode; only consumed while in DECODE.
    always_comb begin
        dec_legal = 1'b0;
        dec_alu   = 3'b000;
        dec_src   = 1'b0;
        dec_imm   = 1'b0;
        dec_m2r   = 1'b0;
        dec_kind  = K_ALU;
        case (opcode)
            OP_RTYPE: begin
                dec_legal = 1'b1;
                case (funct)
                    FN_AND: dec_alu = 3'b000;
                    FN_OR:  dec_alu = 3'b001;
                    FN_SLL: begin dec_alu = 3'b010; dec_src = 1'b1; end
                    FN_SRL: begin dec_alu = 3'b011; dec_src = 1'b1; end
                    FN_SUB: dec_alu = 3'b100;
                    FN_ADD: dec_alu = 3'b101;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                dec_legal = 1'b1;
                dec_alu   = 3'b101;
                dec_src   = 1'b1;
                dec_imm   = 1'b1;
            end
            OP_LW: begin
                dec_legal = 1'b1;
                dec_alu   = 3'b101;
                dec_src   = 1'b1;
                dec_imm   = 1'b1;
                dec_m2r   = 1'b1;
                dec_kind  = K_LOAD;
            end
            OP_SW: begin
                dec_legal = 1'b1;
                dec_alu   = 3'b101;
                dec_src   = 1'b1;
                dec_imm   = 1'b1;
                dec_kind  = K_STORE;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        alucntrl_d = alucntrl_q;
        alusrc_d   = alusrc_q;
        immsel_d   = immsel_q;
        memtoreg_d = memtoreg_q;
        illegal_d  = illegal_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Illegal encodings latch neutral controls so nothing stale leaks out.
                kind_d     = dec_legal ? dec_kind : K_ALU;
                alucntrl_d = dec_legal ? ALUCTRL_W'(dec_alu) : '0;
                alusrc_d   = dec_legal & dec_src;
                immsel_d   = dec_legal & dec_imm;
                memtoreg_d = dec_legal & dec_m2r;
                if (dec_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXECUTE: begin
                state_d = (kind_q == K_ALU) ? S_WRITEBACK : S_MEM;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (kind_q == K_STORE) begin
                        state_d = S_FETCH;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            kind_q     <= K_ALU;
            alucntrl_q <= '0;
            alusrc_q   <= 1'b0;
            immsel_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            alucntrl_q <= alucntrl_d;
            alusrc_q   <= alusrc_d;
            immsel_q   <= immsel_d;
            memtoreg_q <= memtoreg_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
        end
    end

    // Strobes are held low while reset is asserted so an aborted access never
    // writes back or advances the PC in the reset cycle.
    assign mem_req  = reset_n & ((state_q == S_FETCH) | (state_q == S_MEM));
    assign mem_we   = reset_n & (state_q == S_MEM) & (kind_q == K_STORE);
    assign ir_write = reset_n & (state_q == S_FETCH) & mem_ready;
    assign pc_write = reset_n & (state_q == S_FETCH) & mem_ready;
    assign regWrite = reset_n & (state_q == S_WRITEBACK);

    assign alucntrl    = alucntrl_q;
    assign ALUsrc      = alusrc_q;
    assign immsel      = immsel_q;
    assign memtoreg    = memtoreg_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench: per-instruction expected cycle timelines built from the
// instruction-set rules, compared cycle by cycle against the control unit.
module tb_multicycle_control_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [5:0]       opcode = '0;
    logic [5:0]       funct = '0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, ir_write, pc_write;
    logic [2:0]       alucntrl;
    logic             ALUsrc, immsel, memtoreg, regWrite, illegal;
    logic [CNT_W-1:0] instr_count;

    int errs = 0;
    int checks = 0;
    int model_cnt = 0;

    multicycle_control_unit #(
        .OPCODE_W(6), .FUNCT_W(6), .ALUCTRL_W(3), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .pc_write(pc_write), .alucntrl(alucntrl),
        .ALUsrc(ALUsrc), .immsel(immsel), .memtoreg(memtoreg),
        .regWrite(regWrite), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // One expected cycle: input to drive plus strobes {req,we,ir,pc,rw}.
    typedef struct {
        logic       rdy;
        logic       dec;
        logic       ill;
        logic       post;
        logic [4:0] exp;
    } cyc_t;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic cyc_t mk(input logic rdy, input logic dec, input logic ill,
                                input logic post, input logic [4:0] exp);
        cyc_t c;
        c.rdy = rdy; c.dec = dec; c.ill = ill; c.post = post; c.exp = exp;
        return c;
    endfunction

    function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       output bit legal, output logic [2:0] alu,
                                       output bit src, output bit imm, output bit m2r,
                                       output bit ld, output bit st);
        legal = 1; alu = 3'd0; src = 0; imm = 0; m2r = 0; ld = 0; st = 0;
        if (op == 6'h00) begin
            case (fn)
                6'h24: alu = 3'd0;
                6'h25: alu = 3'd1;
                6'h00: begin alu = 3'd2; src = 1; end
                6'h02: begin alu = 3'd3; src = 1; end
                6'h22: alu = 3'd4;
                6'h20: alu = 3'd5;
                default: legal = 0;
            endcase
        end else if (op == 6'h08) begin
            alu = 3'd5; src = 1; imm = 1;
        end else if (op == 6'h23) begin
            alu = 3'd5; src = 1; imm = 1; m2r = 1; ld = 1;
        end else if (op == 6'h2b) begin
            alu = 3'd5; src = 1; imm = 1; st = 1;
        end else begin
            legal = 0;
        end
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                             input int wm, input int trap_n, input int abort_at);
        cyc_t q[$];
        bit legal, src, imm, m2r, ld, st;
        logic [2:0] alu;
        ref_decode(op, fn, legal, alu, src, imm, m2r, ld, st);
        for (int i = 0; i < wf; i++) q.push_back(mk(1'b0, 0, 0, 0, 5'b10000));
        q.push_back(mk(1'b1, 0, 0, 0, 5'b10110));
        q.push_back(mk(1'($urandom_range(0, 1)), 1, 0, 0, 5'b00000));
        if (!legal) begin
            for (int i = 0; i < trap_n; i++)
                q.push_back(mk(1'($urandom_range(0, 1)), 0, 1, 0, 5'b00000));
        end else begin
            q.push_back(mk(1'($urandom_range(0, 1)), 0, 0, 1, 5'b00000));
            if (ld || st) begin
                for (int i = 0; i < wm; i++) q.push_back(mk(1'b0, 0, 0, 1, {1'b1, st, 3'b000}));
                q.push_back(mk(1'b1, 0, 0, 1, {1'b1, st, 3'b000}));
            end
            if (!st) q.push_back(mk(1'($urandom_range(0, 1)), 0, 0, 1, 5'b00001));
        end
        for (int i = 0; i < q.size(); i++) begin
            if (abort_at >= 0 && i >= abort_at) break;
            @(negedge clk);
            mem_ready = q[i].rdy;
            opcode = q[i].dec ? op : 6'($urandom);
            funct  = q[i].dec ? fn : 6'($urandom);
            #1;
            chk("strobes", {mem_req, mem_we, ir_write, pc_write, regWrite}, q[i].exp);
            chk("illegal", illegal, q[i].ill);
            if (i == 0) chk("count", instr_count, model_cnt);
            if (q[i].post) begin
                chk("alucntrl", alucntrl, alu);
                chk("src_imm", {ALUsrc, immsel}, {src, imm});
                if (!st) chk("memtoreg", memtoreg, m2r);
            end
        end
        if (legal && abort_at < 0) model_cnt = (model_cnt + 1) % (1 << CNT_W);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_cycle_wr", {regWrite, pc_write}, 2'b00);
        @(negedge clk);
        #1;
        chk("rst_outputs", {mem_req, mem_we, ir_write, pc_write, regWrite, illegal,
                            ALUsrc, immsel, memtoreg, alucntrl}, 12'h000);
        chk("rst_count", instr_count, 0);
        mem_ready = 1'b0;
        reset_n = 1'b1;
        model_cnt = 0;
    endtask

    logic [5:0] legal_op[9] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2b};
    logic [5:0] legal_fn[9] = '{6'h24, 6'h25, 6'h00, 6'h02, 6'h22, 6'h20, 6'h00, 6'h00, 6'h00};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        do_reset();
        run_instr(6'h00, 6'h20, 0, 0, 0, -1);
        for (int i = 0; i < 6; i++) run_instr(legal_op[i], legal_fn[i], 0, 0, 0, -1);
        run_instr(6'h23, 6'h00, 0, 3, 0, -1);
        run_instr(6'h2b, 6'h00, 0, 0, 0, -1);
        run_instr(6'h2b, 6'h11, 2, 2, 0, -1);
        run_instr(6'h08, 6'h3f, 1, 0, 0, -1);
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 8);
            run_instr(legal_op[k], legal_fn[k], $urandom_range(0, 3), $urandom_range(0, 3), 0, -1);
        end
        // Abort an LW while it waits in MEM.
        run_instr(6'h23, 6'h00, 0, 3, 0, 4);
        do_reset();
        run_instr(6'h00, 6'h20, 0, 0, 0, -1);
        run_instr(6'h3f, 6'($urandom), 0, 0, 5, -1);
        do_reset();
        run_instr(6'h00, 6'h3f, 1, 0, 4, -1);
        do_reset();
        run_instr(6'h23, 6'h00, 1, 1, 0, -1);
        run_instr(6'h00, 6'h22, 0, 0, 0, -1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("final_count", instr_count, model_cnt);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation control unit for the multi-cycle datapath. It replaces single-cycle funct-only decode with a parametrised FSM that sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Handshakes with instruction/data memory through a req/ready pair.
- Decodes opcode and funct into registered datapath controls and flags illegal instructions.
- Counts retired instructions.

Parameters:
- OPCODE_W, 6, opcode field width.
- FUNCT_W, 6, funct field width.
- ALUCTRL_W, 3, ALU control width (must be >= 3).
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on rising clk.
- opcode  input  OPCODE_W  opcode from instruction register.
- funct  input  FUNCT_W  funct from instruction register.
- mem_ready  input  1  memory accepted/completed current request.
- mem_req  output  1  memory request (fetch or data access).
- mem_we  output  1  data write (store); 0 = read.
- ir_write  output  1  load instruction register.
- pc_write  output  1  advance PC.
- alucntrl  output  ALUCTRL_W  ALU operation.
- ALUsrc  output  1  1 = immediate/shamt operand.
- immsel  output  1  1 = sign-extended immediate path.
- memtoreg  output  1  1 = writeback from memory.
- regWrite  output  1  register-file write strobe.
- illegal  output  1  sticky illegal-instruction flag.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- Reset (reset_n=0 at edge): state=FETCH; every output 0; alucntrl=0; instr_count=0. Reset mid-instruction aborts it, with no regWrite/pc_write that cycle or after.
- Decode table. Decode is latched at end of DECODE into registers that drive alucntrl/ALUsrc/immsel/memtoreg until the next DECODE.
  - opcode 000000 (R-type), by funct:
    - AND 100100 -> alucntrl 000, ALUsrc 0
    - OR 100101 -> 001, 0
    - SLL 000000 -> 010, 1
    - SRL 000010 -> 011, 1
    - SUB 100010 -> 100, 0
    - ADD 100000 -> 101, 0
    - immsel=0, memtoreg=0
  - ADDI 001000: alucntrl 101, ALUsrc 1, immsel 1, memtoreg 0.
  - LW 100011: alucntrl 101, ALUsrc 1, immsel 1, memtoreg 1.
  - SW 101011: alucntrl 101, ALUsrc 1, immsel 1.
  - Anything else, including unknown funct under R-type: illegal.
- States:
  - FETCH: mem_req=1, mem_we=0. Stay while mem_ready=0. On mem_ready=1: ir_write=1 and pc_write=1 for that single cycle, then -> DECODE.
  - DECODE: one cycle; latch decode. Illegal -> TRAP; else -> EXECUTE.
  - EXECUTE: one cycle. LW/SW -> MEM; R-type/ADDI -> WRITEBACK.
  - MEM: mem_req=1, mem_we=1 for SW, 0 for LW. Hold until mem_ready=1. Then LW -> WRITEBACK; SW -> FETCH, incrementing instr_count.
  - WRITEBACK: regWrite=1 for exactly one cycle; instr_count++; -> FETCH.
  - TRAP: illegal=1, all strobes 0; remains until reset.
- Strobes (mem_req, ir_write, pc_write, regWrite) are pure functions of state and mem_ready. No strobe is ever asserted in DECODE/EXECUTE/TRAP.
- mem_req must not drop while waiting in FETCH/MEM. opcode/funct are only sampled in DECODE.
- Minimum latency with mem_ready tied high:
  - R-type/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Each mem_ready=0 cycle adds one.
- instr_count wraps modulo 2^CNT_W with no flag. It never increments for illegal instructions.

Test Plan:
- Reset then R-type ADD (opcode 0, funct 100000), mem_ready=1 -> states F,D,E,WB. regWrite high cycle 4 only, alucntrl=101, ALUsrc=0, instr_count=1.
- Every funct (AND, OR, SLL, SRL, SUB, ADD) back-to-back -> alucntrl 000,001,010,011,100,101. ALUsrc=1 only for SLL/SRL. instr_count=6 after 24 cycles.
- LW with mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0, memtoreg=1, regWrite once; total 8 cycles.
- SW -> mem_we=1 in MEM, regWrite never asserted, instr_count+1 on mem_ready.
- opcode 111111 (or R-type funct 111111) -> illegal=1 from the cycle after DECODE, no further mem_req. reset_n=0 clears illegal and returns to FETCH.
- reset_n=0 during MEM of LW -> next cycle all outputs 0, no regWrite. CNT_W=4 and 17 retirements -> instr_count=1.
